// File: rtl/cfg_write_arbiter_pkg.sv
// rtl/cfg_write_arbiter_pkg.sv - shared address map and port-select types for the config bank
package cfg_write_arbiter_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;
    localparam logic [6:0] ADDR_MAX       = 7'd4;

    localparam int NUM_REGS = 5;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // True when the full 7-bit address lands inside the bank
    function automatic logic addr_in_range(input logic [6:0] addr);
        return addr <= ADDR_MAX;
    endfunction

endpackage

// File: rtl/cfg_write_arbiter_rr_arb2.sv
// rtl/cfg_write_arbiter_rr_arb2.sv - two-requester arbiter (round-robin, or fixed priority with CFG_ARB_FIXED_PRIO_EN)
module rr_arb2
    import cfg_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

`ifdef CFG_ARB_FIXED_PRIO_EN

    // A always wins; no history is kept
    always_comb begin
        gnt_a = req_a;
        gnt_b = req_b & ~req_a;
    end

`else

    port_sel_e last_grant_q;
    port_sel_e last_grant_d;

    // Contention goes to whichever port did not win last; history moves only on a grant
    always_comb begin
        gnt_a        = req_a & (~req_b | (last_grant_q == PORT_B));
        gnt_b        = req_b & ~gnt_a;
        last_grant_d = last_grant_q;
        if (gnt_a) begin
            last_grant_d = PORT_A;
        end else if (gnt_b) begin
            last_grant_d = PORT_B;
        end
    end

    // History register; resets to B so A wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`endif

endmodule

// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - five-byte config bank with two arbitrated write ports (CFG_ARB_FIXED_PRIO_EN selects fixed priority)
module cfg_write_arbiter
    import cfg_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_ready,
    input  logic       err_clr,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       commit,
    output logic [2:0] commit_addr,
    output logic       err_addr,
    output logic [7:0] wr_count
);

    logic gnt_a;
    logic gnt_b;

    logic [NUM_REGS-1:0][7:0] bank_q;
    logic [NUM_REGS-1:0][7:0] bank_d;
    logic                     commit_q;
    logic                     commit_d;
    logic [2:0]               commit_addr_q;
    logic [2:0]               commit_addr_d;
    logic                     err_addr_q;
    logic                     err_addr_d;
    logic [7:0]               wr_count_q;
    logic [7:0]               wr_count_d;

    logic       xfer;
    logic [6:0] sel_addr;
    logic [7:0] sel_data;
    logic       wr_en;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_a (a_valid),
        .req_b (b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // Ready follows the grant but is held low while reset is asserted
    always_comb begin
        a_ready = gnt_a & rst_n;
        b_ready = gnt_b & rst_n;
    end

    // Mux the winning request and decide whether it hits the bank or the error flag
    always_comb begin
        xfer     = a_ready | b_ready;
        sel_addr = a_ready ? a_addr : b_addr;
        sel_data = a_ready ? a_data : b_data;
        wr_en    = xfer & addr_in_range(sel_addr);
    end

    // Next-state for the bank, commit strobe, counter and sticky error
    always_comb begin
        bank_d        = bank_q;
        commit_d      = 1'b0;
        commit_addr_d = commit_addr_q;
        err_addr_d    = err_addr_q;
        wr_count_d    = wr_count_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (sel_addr == 7'(i))) begin
                bank_d[i] = sel_data;
            end
        end
        if (wr_en) begin
            commit_d      = 1'b1;
            commit_addr_d = sel_addr[2:0];
            wr_count_d    = wr_count_q + 8'd1;
        end
        // A bad write in the same cycle as a clear leaves the flag set
        if (xfer && !wr_en) begin
            err_addr_d = 1'b1;
        end else if (err_clr) begin
            err_addr_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q        <= '0;
            commit_q      <= 1'b0;
            commit_addr_q <= 3'd0;
            err_addr_q    <= 1'b0;
            wr_count_q    <= 8'd0;
        end else begin
            bank_q        <= bank_d;
            commit_q      <= commit_d;
            commit_addr_q <= commit_addr_d;
            err_addr_q    <= err_addr_d;
            wr_count_q    <= wr_count_d;
        end
    end

    // Bank outputs feed the PWM/output stage directly
    always_comb begin
        en_reg_out_7_0  = bank_q[ADDR_EN_OUT_LO[2:0]];
        en_reg_out_15_8 = bank_q[ADDR_EN_OUT_HI[2:0]];
        en_reg_pwm_7_0  = bank_q[ADDR_EN_PWM_LO[2:0]];
        en_reg_pwm_15_8 = bank_q[ADDR_EN_PWM_HI[2:0]];
        pwm_duty_cycle  = bank_q[ADDR_PWM_DUTY[2:0]];
        commit          = commit_q;
        commit_addr     = commit_addr_q;
        err_addr        = err_addr_q;
        wr_count        = wr_count_q;
    end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - self-checking bench for cfg_write_arbiter
module tb_cfg_write_arbiter;

`ifdef CFG_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0;
    logic [6:0] a_addr = '0;
    logic [7:0] a_data = '0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [6:0] b_addr = '0;
    logic [7:0] b_data = '0;
    logic       b_ready;
    logic       err_clr = 1'b0;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       commit;
    logic [2:0] commit_addr;
    logic       err_addr;
    logic [7:0] wr_count;

    cfg_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .err_clr(err_clr),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle),
        .commit(commit), .commit_addr(commit_addr), .err_addr(err_addr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       av; logic [6:0] aa; logic [7:0] ad;
        logic       bv; logic [6:0] ba; logic [7:0] bd;
        logic       clr;
        logic       e_ar; logic e_br;
        logic       e_commit; logic [2:0] e_caddr; logic e_err; logic [7:0] e_cnt;
        logic [7:0] e_lo; logic [7:0] e_hi; logic [7:0] e_duty;
    } vec_t;

    vec_t vecs[$];

    // Reference model: bank contents and status as the specification describes them
    int m_regs[5];
    int m_last;      // 0 = A won last transfer, 1 = B
    int m_cnt;
    int m_err;
    int m_commit;
    int m_caddr;

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_last = 1; m_cnt = 0; m_err = 0; m_commit = 0; m_caddr = 0;
    endtask

    task automatic check_model_outputs();
        chk("m_out_lo", en_reg_out_7_0, m_regs[0]);
        chk("m_out_hi", en_reg_out_15_8, m_regs[1]);
        chk("m_pwm_lo", en_reg_pwm_7_0, m_regs[2]);
        chk("m_pwm_hi", en_reg_pwm_15_8, m_regs[3]);
        chk("m_duty", pwm_duty_cycle, m_regs[4]);
        chk("m_commit", commit, m_commit);
        chk("m_caddr", commit_addr, m_caddr);
        chk("m_err", err_addr, m_err);
        chk("m_cnt", wr_count, m_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic add(input logic av, input int aa, input int ad, input logic bv, input int ba, input int bd,
                       input logic clr, input logic ear, input logic ebr, input logic ec, input int eca,
                       input logic ee, input int ecnt, input int elo, input int ehi, input int eduty);
        vec_t v;
        v.av = av; v.aa = 7'(aa); v.ad = 8'(ad); v.bv = bv; v.ba = 7'(ba); v.bd = 8'(bd); v.clr = clr;
        v.e_ar = ear; v.e_br = ebr; v.e_commit = ec; v.e_caddr = 3'(eca); v.e_err = ee; v.e_cnt = 8'(ecnt);
        v.e_lo = 8'(elo); v.e_hi = 8'(ehi); v.e_duty = 8'(eduty);
        vecs.push_back(v);
    endtask

    bit a_done, b_done, ga, gb;
    int xa, xd;

    initial begin
        // Directed table, starting from reset (A wins first contention)
        add(0,0,0,    0,0,0,    0, 0,0, 0,0,0, 0, 8'h00,8'h00,8'h00);
        add(1,0,8'h11, 1,1,8'h22, 0, 1,0, 1,0,0, 1, 8'h11,8'h00,8'h00);
        add(1,0,8'h11, 1,1,8'h22, 0, FIXED,!FIXED, 1,FIXED?0:1,0, 2, 8'h11,FIXED?0:8'h22,8'h00);
        add(1,0,8'h11, 1,1,8'h22, 0, 1,0, 1,0,0, 3, 8'h11,FIXED?0:8'h22,8'h00);
        add(1,0,8'h11, 1,1,8'h22, 0, FIXED,!FIXED, 1,FIXED?0:1,0, 4, 8'h11,FIXED?0:8'h22,8'h00);
        add(1,4,8'hAB, 0,0,0,    0, 1,0, 1,4,0, 5, 8'h11,FIXED?0:8'h22,8'hAB);
        add(0,0,0,    1,7'h10,8'h55, 0, 0,1, 0,4,1, 5, 8'h11,FIXED?0:8'h22,8'hAB);
        add(0,0,0,    1,7'h7F,8'h00, 1, 0,1, 0,4,1, 5, 8'h11,FIXED?0:8'h22,8'hAB);
        add(0,0,0,    0,0,0,    1, 0,0, 0,4,0, 5, 8'h11,FIXED?0:8'h22,8'hAB);
        add(1,0,8'hFF, 0,0,0,    0, 1,0, 1,0,0, 6, 8'hFF,FIXED?0:8'h22,8'hAB);
        add(1,0,8'h00, 0,0,0,    0, 1,0, 1,0,0, 7, 8'h00,FIXED?0:8'h22,8'hAB);
        add(0,0,0,    1,5,8'h33, 0, 0,1, 0,0,1, 7, 8'h00,FIXED?0:8'h22,8'hAB);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready_a", a_ready, 0);
        chk("rst_cnt", wr_count, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            err_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_a_ready", i), a_ready, vecs[i].e_ar);
            chk($sformatf("v%0d_b_ready", i), b_ready, vecs[i].e_br);
            @(negedge clk);
            chk($sformatf("v%0d_commit", i), commit, vecs[i].e_commit);
            chk($sformatf("v%0d_caddr", i), commit_addr, vecs[i].e_caddr);
            chk($sformatf("v%0d_err", i), err_addr, vecs[i].e_err);
            chk($sformatf("v%0d_cnt", i), wr_count, vecs[i].e_cnt);
            chk($sformatf("v%0d_lo", i), en_reg_out_7_0, vecs[i].e_lo);
            chk($sformatf("v%0d_hi", i), en_reg_out_15_8, vecs[i].e_hi);
            chk($sformatf("v%0d_duty", i), pwm_duty_cycle, vecs[i].e_duty);
        end
        a_valid = 0; b_valid = 0; err_clr = 0;

        // wr_count wrap: 256 commits from reset
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a_valid = 1; a_addr = 7'd0; a_data = 8'(i);
            @(negedge clk);
            if (i == 254) chk("wrap_cnt_255", wr_count, 8'hFF);
        end
        a_valid = 0;
        chk("wrap_cnt_0", wr_count, 8'h00);
        chk("wrap_last_data", en_reg_out_7_0, 8'hFF);

        // Randomized traffic against the reference model
        do_reset();
        a_done = 0; b_done = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_model_outputs();
            if (a_done) a_valid = 0;
            if (b_done) b_valid = 0;
            if (a_valid && $urandom_range(0, 7) == 0) a_valid = 0;
            else if (!a_valid && $urandom_range(0, 1) == 1) begin
                a_valid = 1;
                a_addr = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127));
                a_data = 8'($urandom);
            end
            if (b_valid && $urandom_range(0, 7) == 0) b_valid = 0;
            else if (!b_valid && $urandom_range(0, 1) == 1) begin
                b_valid = 1;
                b_addr = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(5, 127));
                b_data = 8'($urandom);
            end
            err_clr = ($urandom_range(0, 7) == 0);
            #1;
            // Grant: lone requester wins; on contention the port that did not win last (or A when fixed)
            ga = a_valid && (!b_valid || FIXED || m_last == 1);
            gb = b_valid && !ga;
            chk("r_a_ready", a_ready, ga);
            chk("r_b_ready", b_ready, gb);
            a_done = ga; b_done = gb;
            m_commit = 0;
            if (ga || gb) begin
                xa = ga ? int'(a_addr) : int'(b_addr);
                xd = ga ? int'(a_data) : int'(b_data);
                m_last = ga ? 0 : 1;
                if (xa <= 4) begin
                    m_regs[xa] = xd;
                    m_commit = 1;
                    m_caddr = xa;
                    m_cnt = (m_cnt + 1) % 256;
                end else begin
                    m_err = 1;
                end
            end
            if (!((ga || gb) && xa > 4) && err_clr) m_err = 0;
            @(negedge clk);
        end
        check_model_outputs();

        // Reset pulsed while both ports stream
        a_valid = 1; a_addr = 7'd2; a_data = 8'h5A;
        b_valid = 1; b_addr = 7'd3; b_data = 8'hA5;
        err_clr = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_ready", a_ready, 0);
        chk("mid_rst_b_ready", b_ready, 0);
        chk("mid_rst_pwm_lo", en_reg_pwm_7_0, 0);
        chk("mid_rst_pwm_hi", en_reg_pwm_15_8, 0);
        chk("mid_rst_cnt", wr_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_a_ready", a_ready, 1);
        chk("post_rst_b_ready", b_ready, 0);
        @(negedge clk);
        chk("post_rst_pwm_lo", en_reg_pwm_7_0, 8'h5A);
        chk("post_rst_caddr", commit_addr, 2);
        a_valid = 0; b_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfg_write_arbiter.md
# cfg_write_arbiter

Owns the five-byte output/PWM configuration bank and arbitrates write requests from two requesters: port A (SPI peripheral commit path) and port B (on-chip sequencer or test engine). Accepts at most one write per cycle, decodes the 7-bit address, updates the addressed register and flags out-of-range writes. It sits between the SPI front-end and the PWM/output stage, which consume the bank outputs directly.

## Interface
- No parameters. Bank size is fixed at 5 registers, addresses 0x00–0x04.
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, asynchronous assert, active-low
- a_valid  input  1  port A write request
- a_addr  input  7  port A register address
- a_data  input  8  port A write data
- a_ready  output  1  port A request accepted this cycle
- b_valid, b_addr, b_data, b_ready: same as port A, for port B
- err_clr  input  1  clears err_addr
- en_reg_out_7_0  output  8  register 0x00
- en_reg_out_15_8  output  8  register 0x01
- en_reg_pwm_7_0  output  8  register 0x02
- en_reg_pwm_15_8  output  8  register 0x03
- pwm_duty_cycle  output  8  register 0x04
- commit  output  1  one-cycle strobe: a register was written
- commit_addr  output  3  address of the last committed write
- err_addr  output  1  sticky flag: an accepted request had address > 0x04
- wr_count  output  8  count of committed writes, wraps 0xFF→0x00

## Operation
- Handshake: a transfer occurs when valid && ready. Ready is combinational from this cycle's valid inputs and the arbitration state. Ready is never asserted without the matching valid.
- Requesters hold valid, addr and data stable until ready. Deasserting valid before ready is legal. The request is dropped and nothing is written.
- Arbitration is round-robin. The state is last_grant (A/B).
  - Only one port valid: that port is granted.
  - Both valid: the port not in last_grant is granted.
  - last_grant updates only on a transfer.
- Address 0x00–0x04: the addressed register takes the data on the next edge. commit pulses, commit_addr takes addr[2:0] and wr_count increments.
- Address 0x05–0x7F: the request is accepted (ready high) and no register changes. commit stays low, wr_count is unchanged and err_addr sets.
- err_addr clears on err_clr. If a set and err_clr occur in the same cycle, the set wins.
- Values of 0x00 and 0xFF are written normally. No masking is applied.

## Timing
- Reset values: all five registers 0x00, commit 0, commit_addr 0, err_addr 0, wr_count 0x00. last_grant resets to B, so A wins the first contention.
- Latency: the transfer happens in cycle N. The register output, commit, commit_addr, wr_count and err_addr all update at the edge ending cycle N and are visible in N+1.
- Throughput: one write per cycle, sustained. Under continuous contention the grants alternate A, B, A, B.
- Back-to-back writes to the same address: the later write wins and each one pulses commit.
- Reset asserted mid-operation: all state returns to reset values immediately. Any request in flight is lost. a_ready and b_ready are 0 while rst_n is low.

## Configuration
- CFG_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, A always beats B. last_grant is not implemented. B can starve under continuous A traffic, which is acceptable because SPI writes are sparse.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Shared package: register address constants (ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_PWM_DUTY=4, ADDR_MAX=4) and a port-select enum (PORT_A, PORT_B). The SPI peripheral and the PWM stage import the same package.
- Sub-module: rr_arb2, a two-requester arbiter holding last_grant and producing one-hot grants. The top level holds the mux, decode, bank, counter and error flag.

## Test plan
- Reset release, no requests: all outputs 0, a_ready = b_ready = 0.
- A writes 0x04/0xAB: a_ready high in the same cycle. Next cycle: pwm_duty_cycle = 0xAB, commit = 1, commit_addr = 4, wr_count = 1.
- A and B both valid for 4 cycles, A→0x00 and B→0x01 with differing data: grants go A, B, A, B and wr_count = 4. In the fixed-priority build, B is never granted.
- B writes 0x10/0x55: b_ready = 1, no register changes, commit = 0, err_addr = 1. Issue err_clr plus another bad write in the same cycle: err_addr stays 1. A lone err_clr then clears it.
- 256 commits from 0: wr_count returns to 0x00.
- rst_n pulsed low while A and B are streaming: all registers read 0 during reset, and A wins the first grant after release.
